bcd_change_dispenser: RTL and testbench
=======================================

Name: bcd_change_dispenser

Overview:
- Vending-machine change payout block: loads a two-digit BCD change amount, then counts it down to 00 while issuing one coin-eject request per coin to the coin ejector over a req/ack handshake.
- Down-counting counterpart of the credit-accumulating BCD counter: that counter tallies coins in, this block pays coins out.
- Sits between the vending controller (load/done/error) and the coin ejector (coin_req/coin_ack).

Parameters:
- ACK_TIMEOUT, 255, max cycles coin_req may stay high without coin_ack before fault; must be >= 1.
- TO_W, 8, timeout counter width; must hold ACK_TIMEOUT.
- TEN_COINS_EN, 1, 1 = pay tens as 10-unit coins then ones as 1-unit coins; 0 = pay everything as 1-unit coins using BCD borrow.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle start strobe from the controller.
- change_tens  in  4  BCD tens digit of the amount, sampled with load.
- change_ones  in  4  BCD ones digit of the amount, sampled with load.
- coin_ack  in  1  ejector acknowledge, level.
- coin_req  out  1  eject request, level.
- coin_sel  out  1  1 = 10-unit coin, 0 = 1-unit coin; valid while coin_req = 1.
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse when payout completes.
- error  out  1  fault flag.
- remain_tens  out  4  BCD tens digit still owed.
- remain_ones  out  4  BCD ones digit still owed.

Behaviour:
- Reset (sync, rst = 1 at a clk edge): state IDLE; coin_req, coin_sel, busy, done, error = 0; remain = 00; timeout counter = 0. Reset overrides everything, including mid-handshake; coin_req drops the next cycle.
- States: IDLE, CHECK, REQ, WAIT_LOW, DONE, FAULT.
- IDLE: load = 1 latches both digits into remain.
  - If either digit > 9: go to FAULT, remain = 00, no req.
  - Otherwise: go to CHECK and clear error.
- CHECK (1 cycle, busy = 1):
  - remain = 00: go to DONE (zero payout issues no req).
  - Otherwise go to REQ.
  - coin_sel = 1 if TEN_COINS_EN and remain_tens != 0, else 0.
- REQ: coin_req = 1, coin_sel held stable; timeout counter increments each cycle.
  - coin_ack = 1: go to WAIT_LOW and decrement the owed amount on the same edge.
    - Tens coin: tens - 1.
    - Ones coin with ones != 0: ones - 1.
    - Ones coin with ones = 0 (only when TEN_COINS_EN = 0): ones = 9, tens - 1 (BCD borrow).
    - remain never wraps below 00.
  - Counter reaches ACK_TIMEOUT with no ack: go to FAULT.
- WAIT_LOW: coin_req = 0; wait for coin_ack = 0 (four-phase handshake).
  - Then go to DONE if remain = 00, else CHECK.
  - Next coin_req rises at the earliest 2 cycles after coin_ack is seen low.
  - No timeout in this state.
- DONE: done = 1 for exactly one cycle, busy = 1 in that cycle, then IDLE.
- FAULT: error = 1 (sticky), busy = 0, coin_req = 0; remain keeps the amount still owed.
  - Leave only via rst, or via load once coin_ack = 0, which re-enters the IDLE load path.
- load while busy: ignored, no effect on remain or state.
- coin_ack high in IDLE or CHECK: ignored; a REQ entered with ack already high is treated as acknowledged on its first cycle.
- Outputs are registered; remain outputs are driven directly from the counter registers.
- Latency: load to first coin_req is 2 cycles; last ack to done is 1 cycle plus the time for ack to fall.

Decomposition:
- Shared package/include holds:
  - State encodings (3-bit).
  - The BCD_MAX = 9 constant.
  - COIN_TEN = 1 and COIN_ONE = 0.
- One natural sub-module: bcd_down_digit, a single BCD digit with load, dec, borrow_in and borrow_out that wraps 0 to 9 on borrow. It is instantiated twice, with the ones digit's borrow_out chained to the tens digit.

Test Plan:
- Reset, then load 3/7, ejector acks 1 cycle after req and drops 1 cycle later: 3 reqs with coin_sel = 1, then 7 with coin_sel = 0; remain steps 37→27→17→07→06…→00; one done pulse; no error.
- TEN_COINS_EN = 0, load 2/0: 20 reqs all with coin_sel = 0; after the first ack remain = 19 (borrow); done after the 20th.
- Load 0/0: no coin_req; done pulses exactly 2 cycles after load.
- Load C/4 (invalid tens): error = 1, busy = 0, no req; then load 0/1 with valid handshake clears error, 1 coin, done.
- Never ack with ACK_TIMEOUT = 5: coin_req high for 5 cycles, then FAULT with error = 1, coin_req = 0, remain unchanged (e.g. 05).
- Assert rst while coin_req = 1 mid-payout of 1/2, and separately pulse load while busy: rst leaves all outputs 0 and remain = 00 next cycle; load while busy leaves remain and state unchanged.

Source files
------------

// File: rtl/bcd_change_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_change_dispenser_pkg
// Description : Shared state encodings, BCD limits and coin codes for the
//               change payout block.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_change_dispenser_pkg;

    // Largest legal value of one BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Coin denominations as presented on coin_sel.
    localparam logic COIN_TEN = 1'b1;
    localparam logic COIN_ONE = 1'b0;

    // Payout controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // True when a nibble is a legal BCD digit.
    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_change_dispenser_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : One BCD down-counting digit. Parallel load, decrement on
//               i_dec or an incoming borrow, wraps 0 -> 9 and flags a borrow
//               to the next digit when it does.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
    import bcd_change_dispenser_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    input  logic       i_borrow_in,
    output logic       o_borrow_out,
    output logic [3:0] o_digit
);

    logic [3:0] r_digit;
    logic       w_step;

    assign w_step       = i_dec | i_borrow_in;
    assign o_borrow_out = w_step & (r_digit == 4'd0);
    assign o_digit      = r_digit;

    // Digit register: load has priority over stepping; 0 steps to 9.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= i_load_val;
        end else if (w_step) begin
            r_digit <= (r_digit == 4'd0) ? BCD_MAX : (r_digit - 4'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : bcd_change_dispenser
// Description : Loads a two-digit BCD change amount and pays it out one coin
//               at a time over a four-phase coin_req/coin_ack handshake,
//               counting the owed amount down to 00.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_change_dispenser
    import bcd_change_dispenser_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 255,
    parameter int TO_W         = 8,
    parameter bit TEN_COINS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] change_tens,
    input  logic [3:0] change_ones,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic       coin_sel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] remain_tens,
    output logic [3:0] remain_ones
);

    // Counter value on the last REQ cycle that may still wait for an ack.
    localparam logic [TO_W-1:0] c_to_last = TO_W'(ACK_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_coin_req;
    logic            r_coin_sel;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [TO_W-1:0] r_to_cnt;

    logic            w_coin_req_nxt;
    logic            w_coin_sel_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_error_nxt;

    logic [3:0]      w_tens;
    logic [3:0]      w_ones;
    logic            w_remain_zero;
    logic            w_load_take;
    logic            w_load_bcd;
    logic            w_pay;
    logic            w_sel_calc;
    logic            w_ones_borrow;
    logic            w_unused_tens_borrow;

    // A load is accepted when idle, or in fault once the ejector has let go.
    assign w_load_take   = load & ((r_state == ST_IDLE) |
                                   ((r_state == ST_FAULT) & ~coin_ack));
    assign w_load_bcd    = is_bcd(change_tens) & is_bcd(change_ones);
    assign w_remain_zero = (w_tens == 4'd0) & (w_ones == 4'd0);
    assign w_pay         = (r_state == ST_REQ) & coin_ack;
    assign w_sel_calc    = (TEN_COINS_EN && (w_tens != 4'd0)) ? COIN_TEN : COIN_ONE;

    // Ones digit pays 1-unit coins; a borrow out of it takes one ten.
    bcd_down_digit u_ones (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load_take),
        .i_load_val   (w_load_bcd ? change_ones : 4'd0),
        .i_dec        (w_pay & (r_coin_sel == COIN_ONE) & ~w_remain_zero),
        .i_borrow_in  (1'b0),
        .o_borrow_out (w_ones_borrow),
        .o_digit      (w_ones)
    );

    // Tens digit pays 10-unit coins and absorbs borrows from the ones digit.
    bcd_down_digit u_tens (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load_take),
        .i_load_val   (w_load_bcd ? change_tens : 4'd0),
        .i_dec        (w_pay & (r_coin_sel == COIN_TEN) & (w_tens != 4'd0)),
        .i_borrow_in  (w_ones_borrow),
        .o_borrow_out (w_unused_tens_borrow),
        .o_digit      (w_tens)
    );

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_FAULT: begin
                if (w_load_take) begin
                    w_state_nxt = w_load_bcd ? ST_CHECK : ST_FAULT;
                end
            end
            ST_CHECK: begin
                w_state_nxt = w_remain_zero ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                if (coin_ack) begin
                    w_state_nxt = ST_WAIT_LOW;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_WAIT_LOW: begin
                if (!coin_ack) begin
                    w_state_nxt = w_remain_zero ? ST_DONE : ST_CHECK;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_coin_req_nxt = (w_state_nxt == ST_REQ);
        w_busy_nxt     = (w_state_nxt == ST_CHECK) | (w_state_nxt == ST_REQ) |
                         (w_state_nxt == ST_WAIT_LOW) | (w_state_nxt == ST_DONE);
        w_done_nxt     = (w_state_nxt == ST_DONE);
        w_error_nxt    = (w_state_nxt == ST_FAULT);
        // Coin type is chosen in CHECK and frozen for the whole request.
        w_coin_sel_nxt = COIN_ONE;
        if (w_state_nxt == ST_REQ) begin
            w_coin_sel_nxt = (r_state == ST_CHECK) ? w_sel_calc : r_coin_sel;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_coin_req <= 1'b0;
            r_coin_sel <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_coin_req <= w_coin_req_nxt;
            r_coin_sel <= w_coin_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // Ack timeout counter: counts unacknowledged REQ cycles, zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_REQ) && (w_state_nxt == ST_REQ)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign coin_req    = r_coin_req;
    assign coin_sel    = r_coin_sel;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign remain_tens = w_tens;
    assign remain_ones = w_ones;

endmodule
`default_nettype wire

// File: tb/tb_bcd_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_change_dispenser
// Description : Self-checking bench. Two dispensers (tens coins enabled with
//               a 5-cycle ack timeout, ones-only with a 9-cycle timeout) share
//               load stimulus; each has its own randomised coin ejector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_change_dispenser;

    localparam int N = 2;
    localparam bit TEN_OF [N] = '{1'b1, 1'b0};
    localparam int TMO_OF [N] = '{5, 9};

    localparam int P_IDLE  = 0;
    localparam int P_CHECK = 1;
    localparam int P_REQ   = 2;
    localparam int P_WAIT  = 3;
    localparam int P_DONE  = 4;
    localparam int P_FAULT = 5;

    typedef struct {
        int ph;
        int owed;
        int coin;
        int t;
    } mstate_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic [N-1:0] ack_v;
    logic [N-1:0] req_v;
    logic [N-1:0] sel_v;
    logic [N-1:0] busy_v;
    logic [N-1:0] done_v;
    logic [N-1:0] err_v;
    logic [3:0]   rt_v [N];
    logic [3:0]   ro_v [N];

    bit           ej_en  [N];
    int           ej_max [N];
    bit           chk_en = 1'b0;
    int           n_tests = 0;
    int           n_fail  = 0;

    mstate_t      ms [N];
    int           n_ten [N];
    int           n_one [N];
    int           n_dn  [N];
    logic [N-1:0] req_q;

    always #5 clk = ~clk;

    // Owed amount as a plain integer; a coin is 10 when tens coins are
    // enabled and at least ten is owed, otherwise 1.
    function automatic mstate_t model_step(mstate_t s, bit ten, int tmo, bit r,
                                           bit ld, int dt, int d1, bit ak);
        mstate_t n;
        n = s;
        if (r) begin
            n.ph = P_IDLE; n.owed = 0; n.coin = 1; n.t = 0;
        end else begin
            case (s.ph)
                P_IDLE, P_FAULT: begin
                    if (ld && (s.ph == P_IDLE || !ak)) begin
                        if (dt > 9 || d1 > 9) begin
                            n.ph = P_FAULT; n.owed = 0;
                        end else begin
                            n.ph = P_CHECK; n.owed = dt * 10 + d1;
                        end
                    end
                end
                P_CHECK: begin
                    n.t = 0;
                    if (s.owed == 0) n.ph = P_DONE;
                    else begin
                        n.ph   = P_REQ;
                        n.coin = (ten && s.owed >= 10) ? 10 : 1;
                    end
                end
                P_REQ: begin
                    if (ak) begin
                        n.owed = s.owed - s.coin;
                        n.ph   = P_WAIT;
                    end else begin
                        n.t = s.t + 1;
                        if (n.t >= tmo) n.ph = P_FAULT;
                    end
                end
                P_WAIT: begin
                    if (!ak) n.ph = (s.owed == 0) ? P_DONE : P_CHECK;
                end
                default: n.ph = P_IDLE;
            endcase
        end
        return n;
    endfunction

    function automatic logic [12:0] exp_vec(mstate_t s);
        logic       rq;
        logic       bz;
        logic [3:0] dt;
        logic [3:0] d1;
        rq = (s.ph == P_REQ);
        bz = (s.ph == P_CHECK) || (s.ph == P_REQ) || (s.ph == P_WAIT) || (s.ph == P_DONE);
        dt = 4'(s.owed / 10);
        d1 = 4'(s.owed % 10);
        return {rq, rq && (s.coin == 10), bz, s.ph == P_DONE, s.ph == P_FAULT, dt, d1};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_inst
        logic ej_ack;
        int   ej_st;
        int   ej_cnt;

        assign ack_v[g] = ej_ack;

        bcd_change_dispenser #(
            .ACK_TIMEOUT  (TMO_OF[g]),
            .TO_W         (8),
            .TEN_COINS_EN (TEN_OF[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .load        (load),
            .change_tens (tens),
            .change_ones (ones),
            .coin_ack    (ej_ack),
            .coin_req    (req_v[g]),
            .coin_sel    (sel_v[g]),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .error       (err_v[g]),
            .remain_tens (rt_v[g]),
            .remain_ones (ro_v[g])
        );

        // Coin ejector: random ack delay after req, random release after req drops.
        initial begin
            ej_ack = 1'b0; ej_st = 0; ej_cnt = 0;
            forever begin
                @(posedge clk); #2;
                if (rst) begin
                    ej_st = 0; ej_ack = 1'b0;
                end else begin
                    case (ej_st)
                        0: if (req_v[g] && ej_en[g]) begin
                               ej_cnt = $urandom_range(0, ej_max[g]);
                               if (ej_cnt == 0) begin ej_ack = 1'b1; ej_st = 2; end
                               else ej_st = 1;
                           end
                        1: if (!req_v[g]) ej_st = 0;
                           else begin
                               ej_cnt--;
                               if (ej_cnt == 0) begin ej_ack = 1'b1; ej_st = 2; end
                           end
                        2: if (!req_v[g]) begin
                               ej_cnt = $urandom_range(0, ej_max[g]);
                               if (ej_cnt == 0) begin ej_ack = 1'b0; ej_st = 0; end
                               else ej_st = 3;
                           end
                        default: begin
                               ej_cnt--;
                               if (ej_cnt == 0) begin ej_ack = 1'b0; ej_st = 0; end
                           end
                    endcase
                end
            end
        end
    end

    // Reference model advance on every active edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            ms[i] <= model_step(ms[i], TEN_OF[i], TMO_OF[i], rst, load,
                                int'(tens), int'(ones), ack_v[i]);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("cycle_outputs[%0d]", i),
                      32'({req_v[i], req_v[i] & sel_v[i], busy_v[i], done_v[i],
                           err_v[i], rt_v[i], ro_v[i]}),
                      32'(exp_vec(ms[i])));
            end
        end
    end

    // Event tallies: coin requests by type and done pulses.
    always @(negedge clk) begin
        req_q <= req_v;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                if (req_v[i] && !req_q[i]) begin
                    if (sel_v[i]) n_ten[i] <= n_ten[i] + 1;
                    else          n_one[i] <= n_one[i] + 1;
                end
                if (done_v[i]) n_dn[i] <= n_dn[i] + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; tens = t; ones = o;
        tick(1);
        load = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int c;
        c = 0;
        while ((busy_v != '0 || req_v != '0) && c < bound) begin
            tick(1); c++;
        end
        if (c >= bound) check({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_req(input int idx, input logic lvl, input int bound, input string nm);
        int c;
        c = 0;
        while (req_v[idx] !== lvl && c < bound) begin
            tick(1); c++;
        end
        if (c >= bound) check({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_ten [N];
        int s_one [N];
        int s_dn  [N];
        int hi    [N];

        rst = 1'b1; load = 1'b0; tens = 4'd0; ones = 4'd0;
        ej_en  = '{1'b1, 1'b1};
        ej_max = '{0, 0};
        @(posedge clk); #1;
        chk_en = 1'b1;
        tick(1);
        check("reset_outputs",
              32'({req_v, sel_v, busy_v, done_v, err_v, rt_v[0], ro_v[0], rt_v[1], ro_v[1]}),
              32'd0);
        rst = 1'b0;
        tick(2);

        // 37: A pays 3 tens then 7 ones; B pays 37 ones.
        s_ten = n_ten; s_one = n_one; s_dn = n_dn;
        pulse_load(4'd3, 4'd7);
        wait_idle(3000, "pay37");
        check("pay37_A_tens", 32'(n_ten[0] - s_ten[0]), 32'd3);
        check("pay37_A_ones", 32'(n_one[0] - s_one[0]), 32'd7);
        check("pay37_B_ones", 32'(n_one[1] - s_one[1]), 32'd37);
        check("pay37_B_tens", 32'(n_ten[1] - s_ten[1]), 32'd0);
        check("pay37_done",   32'({n_dn[0] - s_dn[0], n_dn[1] - s_dn[1]}), 32'({32'd1, 32'd1}));
        check("pay37_err",    32'(err_v), 32'd0);

        // 20: B borrows to 19 after its first coin.
        s_ten = n_ten; s_one = n_one;
        pulse_load(4'd2, 4'd0);
        wait_req(1, 1'b1, 20, "pay20_req");
        wait_req(1, 1'b0, 20, "pay20_ack");
        check("pay20_B_borrow", 32'({rt_v[1], ro_v[1]}), 32'h19);
        wait_idle(3000, "pay20");
        check("pay20_B_ones", 32'(n_one[1] - s_one[1]), 32'd20);
        check("pay20_A_tens", 32'(n_ten[0] - s_ten[0]), 32'd2);

        // 00: no request, done two cycles after load.
        s_one = n_one; s_ten = n_ten;
        pulse_load(4'd0, 4'd0);
        check("zero_cyc1", 32'({done_v, busy_v}), 32'b0011);
        tick(1);
        check("zero_cyc2", 32'({done_v, req_v}), 32'b1100);
        tick(1);
        check("zero_after", 32'({done_v, busy_v, req_v}), 32'd0);
        check("zero_noreq", 32'((n_one[0] + n_ten[0] + n_one[1] + n_ten[1]) -
                                (s_one[0] + s_ten[0] + s_one[1] + s_ten[1])), 32'd0);

        // Invalid tens digit faults; a valid load then recovers.
        pulse_load(4'hC, 4'd4);
        check("bad_fault", 32'({err_v, busy_v, req_v, rt_v[0], ro_v[0]}), 32'({2'b11, 4'b0, 8'h00}));
        tick(3);
        s_dn = n_dn; s_one = n_one;
        pulse_load(4'd0, 4'd1);
        wait_idle(200, "recover01");
        check("recover_err",  32'(err_v), 32'd0);
        check("recover_coin", 32'({n_one[0] - s_one[0], n_one[1] - s_one[1]}), 32'({32'd1, 32'd1}));
        check("recover_done", 32'({n_dn[0] - s_dn[0], n_dn[1] - s_dn[1]}), 32'({32'd1, 32'd1}));

        // No ack at all: request held for exactly the timeout, then fault.
        ej_en = '{1'b0, 1'b0};
        pulse_load(4'd0, 4'd5);
        hi = '{0, 0};
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) hi[i] += int'(req_v[i]);
            tick(1);
        end
        check("timeout_len_A", 32'(hi[0]), 32'd5);
        check("timeout_len_B", 32'(hi[1]), 32'd9);
        check("timeout_state", 32'({err_v, req_v, busy_v, rt_v[0], ro_v[0], rt_v[1], ro_v[1]}),
              32'({2'b11, 4'b0, 16'h0505}));
        ej_en = '{1'b1, 1'b1};
        pulse_load(4'd0, 4'd0);
        wait_idle(50, "timeout_recover");
        check("timeout_recover_err", 32'(err_v), 32'd0);

        // Load while busy is ignored.
        ej_en = '{1'b0, 1'b0};
        pulse_load(4'd3, 4'd4);
        tick(1);
        pulse_load(4'd9, 4'd9);
        check("busy_load_ignored", 32'({req_v, rt_v[0], ro_v[0], rt_v[1], ro_v[1]}),
              32'({2'b11, 16'h3434}));
        rst = 1'b1; tick(1); rst = 1'b0;
        ej_en = '{1'b1, 1'b1};

        // Reset in the middle of a handshake.
        pulse_load(4'd1, 4'd2);
        wait_req(0, 1'b1, 10, "midrst_req");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_outputs",
              32'({req_v, sel_v, busy_v, done_v, err_v, rt_v[0], ro_v[0], rt_v[1], ro_v[1]}),
              32'd0);
        tick(3);

        // Randomised loads, handshake timing and occasional resets.
        for (int it = 0; it < 70; it++) begin
            ej_max[0] = $urandom_range(0, 6);
            ej_max[1] = $urandom_range(0, 4);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end else begin
                pulse_load(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
            end
            tick($urandom_range(0, 60));
        end
        wait_idle(5000, "random_drain");
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
